icnd2110_in: RTL and testbench

- Receiver and decoder for the ICND2110 serial LED-driver stream, the inverse of the ICND2110 output block.
- Oversamples the serial clock and data lines in the system clock domain, frames the stream (start run, blanks, config word, per-chip word groups, end run), and writes the decoded 16-bit words into frame memory.
- The write address mapping inverts the transmitter's ordering, so a loopback of the output block reproduces the source memory image.
- Used for loopback self-test and for sniffing a chained driver line.

---
 rtl/icnd2110_pkg.sv | 50 +++++
 rtl/icnd2110_sampler.sv | 51 +++++
 rtl/icnd2110_in.sv | 274 +++++++++++++++++++++++++++
 tb/tb_icnd2110_in.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/icnd2110_pkg.sv
// ---------------------------------------------------------------------------
// icnd2110_pkg
// Shared constants and types for the ICND2110 serial stream blocks (receiver
// and output block). Holds the frame geometry, the run-length thresholds
// used for frame start/end detection, the receiver FSM encoding and the
// saturating ones-run step function.
// ---------------------------------------------------------------------------
package icnd2110_pkg;

   // Frame geometry
   localparam int BLANK_BITS      = 16;
   localparam int WORD_BITS       = 16;
   localparam int WORDS_PER_GROUP = 6;
   localparam int WORDS_PER_CHIP  = 12;
   localparam int GROUP_BITS      = WORDS_PER_GROUP * WORD_BITS;

   // Run-length thresholds, sized to match the 8-bit ones_run counter
   localparam logic [7:0] START_ONES_MIN = 8'd128;
   localparam logic [7:0] START_ONES_MAX = 8'd143;
   localparam logic [7:0] END_ONES_MIN   = 8'd144;
   // A 1 directly after a full all-ones group: the group's 96 ones plus this one
   localparam logic [7:0] FRAME_END_ONES = 8'(GROUP_BITS + 1);

   // Last-bit values of the 7-bit bit counter for each framed field
   localparam logic [6:0] BLANK_LAST = 7'(BLANK_BITS - 1);
   localparam logic [6:0] WORD_LAST  = 7'(WORD_BITS - 1);
   localparam logic [6:0] GROUP_LAST = 7'(GROUP_BITS - 1);

   typedef enum logic [2:0] {
      HUNT,
      SYNC_BLANK,
      REG,
      BLANK,
      GROUP,
      END
   } state_t;

   // Ones-run counter step: count 1 bits, saturate at 255, clear on a 0 bit
   function automatic logic [7:0] ones_run_step(input logic [7:0] run, input logic b);
      logic [7:0] nxt;
      if (!b)
         nxt = 8'd0;
      else if (run == 8'hFF)
         nxt = run;
      else
         nxt = run + 8'd1;
      return nxt;
   endfunction

endpackage

// File: rtl/icnd2110_sampler.sv
// ---------------------------------------------------------------------------
// icnd2110_sampler
// Brings the asynchronous serial clock/data lines into the clk domain and
// turns each rising edge of the serial clock into a one-cycle bit event.
//   clk         : system clock
//   rst         : asynchronous active-low reset
//   i_sclk      : serial clock from the line (async)
//   i_sdi       : serial data from the line (async)
//   o_bit_valid : one-clk pulse per sampled bit
//   o_bit_value : bit value, valid with o_bit_valid
// ---------------------------------------------------------------------------
module icnd2110_sampler (
   input  logic clk,
   input  logic rst,
   input  logic i_sclk,
   input  logic i_sdi,
   output logic o_bit_valid,
   output logic o_bit_value
);

   logic r_sclk_p0, r_sclk_p1, r_sclk_p2;
   logic r_sdi_p0,  r_sdi_p1;
   logic r_vld_p3,  r_bit_p3;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_sclk_p0 <= 1'b0;
         r_sclk_p1 <= 1'b0;
         r_sclk_p2 <= 1'b0;
         r_sdi_p0  <= 1'b0;
         r_sdi_p1  <= 1'b0;
         r_vld_p3  <= 1'b0;
         r_bit_p3  <= 1'b0;
      end else begin
         // p0/p1: two-flop synchronizers on both lines
         r_sclk_p0 <= i_sclk;
         r_sclk_p1 <= r_sclk_p0;
         r_sdi_p0  <= i_sdi;
         r_sdi_p1  <= r_sdi_p0;
         // p2: previous synced sclk for edge detection
         r_sclk_p2 <= r_sclk_p1;
         // p3: data has the same sync latency as sclk, so it is captured with the edge
         r_vld_p3  <= r_sclk_p1 & ~r_sclk_p2;
         r_bit_p3  <= r_sdi_p1;
      end
   end

   assign o_bit_valid = r_vld_p3;
   assign o_bit_value = r_bit_p3;

endmodule

// File: rtl/icnd2110_in.sv
// ---------------------------------------------------------------------------
// icnd2110_in
// Receiver/decoder for the ICND2110 serial LED-driver stream. Frames the
// oversampled stream (start run, sync blank, config word, blank/group pairs,
// end run) and writes decoded words so that chip n word w lands at
// START_ADDRESS + 12n + w, undoing the transmitter's word ordering.
//   clk, rst               : system clock, asynchronous active-low reset
//   sclk_in, sdi_in        : serial line (async to clk)
//   write_address/_data    : decoded word and its address, valid with write_strobe
//   config_word/_strobe    : last register word, pulse on update
//   frame_strobe           : pulse on a valid frame end, chip_count valid with it
//   chip_count             : chips completed in the last frame (held)
//   error_strobe           : pulse on protocol violation or first dropped word
//   busy                   : frame in progress
// ---------------------------------------------------------------------------
module icnd2110_in #(
   parameter int START_ADDRESS     = 0,
   parameter int WORD_COUNT        = 336,
   parameter int ADDRESS_BUS_WIDTH = 12,
   parameter int CHIP_COUNT_WIDTH  = 8
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         sclk_in,
   input  logic                         sdi_in,
   output logic [ADDRESS_BUS_WIDTH-1:0] write_address,
   output logic [15:0]                  write_data,
   output logic                         write_strobe,
   output logic [15:0]                  config_word,
   output logic                         config_strobe,
   output logic                         frame_strobe,
   output logic [CHIP_COUNT_WIDTH-1:0]  chip_count,
   output logic                         error_strobe,
   output logic                         busy
);

   import icnd2110_pkg::*;

   // Offset from START_ADDRESS; 12*(2^C-1)+11 always fits in C+4 bits
   localparam int OFF_W = CHIP_COUNT_WIDTH + 5;

   logic                        w_bit_valid, w_bit_value;
   logic [7:0]                  w_ones_nxt;
   state_t                      r_state, w_state_nxt;

   logic                        w_start, w_err_fsm, w_cfg_load, w_launch;
   logic                        w_grp_done, w_frame_end, w_frame_ok;

   logic [7:0]                  r_ones_run;
   logic [6:0]                  r_bit_cnt;
   logic [WORD_BITS-2:0]        r_shift;
   logic [GROUP_BITS-1:0]       r_grp;
   logic                        r_half;
   logic [CHIP_COUNT_WIDTH-1:0] r_chip;
   logic [OFF_W-1:0]            r_base;

   logic                        r_pend, r_pend_half;
   logic [OFF_W-1:0]            r_pend_base;

   logic                        r_cm_act, r_cm_half;
   logic [2:0]                  r_cm_k;
   logic [OFF_W-1:0]            r_cm_base;
   logic                        r_ovf_seen;

   logic [OFF_W-1:0]            w_cm_off;
   logic [15:0]                 w_cm_word;
   logic                        w_cm_in_range;

   icnd2110_sampler u_sampler (
      .clk         (clk),
      .rst         (rst),
      .i_sclk      (sclk_in),
      .i_sdi       (sdi_in),
      .o_bit_valid (w_bit_valid),
      .o_bit_value (w_bit_value)
   );

   assign w_ones_nxt = ones_run_step(r_ones_run, w_bit_value);

   // Word k of a group came k-th off the line; first half maps to base+5-k,
   // second half to base+11-k.
   assign w_cm_off      = r_cm_base
                        + (r_cm_half ? OFF_W'(WORDS_PER_CHIP - 1) : OFF_W'(WORDS_PER_GROUP - 1))
                        - OFF_W'(r_cm_k);
   assign w_cm_word     = r_grp[(WORDS_PER_GROUP - 1 - int'(r_cm_k)) * WORD_BITS +: WORD_BITS];
   assign w_cm_in_range = 32'(w_cm_off) < 32'(WORD_COUNT);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         r_state <= HUNT;
      else
         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_start     = 1'b0;
      w_err_fsm   = 1'b0;
      w_cfg_load  = 1'b0;
      w_launch    = 1'b0;
      w_grp_done  = 1'b0;
      w_frame_end = 1'b0;
      w_frame_ok  = 1'b0;
      if (w_bit_valid) begin
         case (r_state)
            HUNT: begin
               // Runs of >=144 are end markers and are ignored here
               if (!w_bit_value && r_ones_run >= START_ONES_MIN && r_ones_run <= START_ONES_MAX) begin
                  w_start     = 1'b1;
                  w_state_nxt = SYNC_BLANK;
               end
            end
            SYNC_BLANK: begin
               if (w_bit_value) begin
                  w_err_fsm   = 1'b1;
                  w_state_nxt = HUNT;
               end else if (r_bit_cnt == BLANK_LAST) begin
                  w_state_nxt = REG;
               end
            end
            REG: begin
               if (r_bit_cnt == WORD_LAST) begin
                  w_cfg_load  = 1'b1;
                  w_state_nxt = BLANK;
               end
            end
            BLANK: begin
               if (w_bit_value) begin
                  // The end run first decodes as a full first-half group of ones
                  if (r_half && w_ones_nxt >= FRAME_END_ONES) begin
                     w_frame_end = 1'b1;
                     w_state_nxt = END;
                  end else begin
                     w_err_fsm   = 1'b1;
                     w_state_nxt = HUNT;
                  end
               end else begin
                  w_launch = r_pend;
                  if (r_bit_cnt == BLANK_LAST)
                     w_state_nxt = GROUP;
               end
            end
            GROUP: begin
               if (r_bit_cnt == GROUP_LAST) begin
                  w_grp_done  = 1'b1;
                  w_state_nxt = BLANK;
               end
            end
            END: begin
               if (!w_bit_value) begin
                  w_state_nxt = HUNT;
                  if (r_ones_run >= END_ONES_MIN)
                     w_frame_ok = 1'b1;
                  else
                     w_err_fsm = 1'b1;
               end
            end
            default: w_state_nxt = HUNT;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         write_address <= '0;
         write_data    <= '0;
         write_strobe  <= 1'b0;
         config_word   <= '0;
         config_strobe <= 1'b0;
         frame_strobe  <= 1'b0;
         chip_count    <= '0;
         error_strobe  <= 1'b0;
         busy          <= 1'b0;
         r_ones_run    <= '0;
         r_bit_cnt     <= '0;
         r_shift       <= '0;
         r_grp         <= '0;
         r_half        <= 1'b0;
         r_chip        <= '0;
         r_base        <= '0;
         r_pend        <= 1'b0;
         r_pend_half   <= 1'b0;
         r_pend_base   <= '0;
         r_cm_act      <= 1'b0;
         r_cm_half     <= 1'b0;
         r_cm_k        <= '0;
         r_cm_base     <= '0;
         r_ovf_seen    <= 1'b0;
      end else begin
         write_strobe  <= 1'b0;
         config_strobe <= 1'b0;
         frame_strobe  <= 1'b0;
         error_strobe  <= 1'b0;

         if (w_bit_valid) begin
            r_ones_run <= w_ones_nxt;
            // The start-detecting 0 already counts as the first sync blank bit
            if (w_state_nxt != r_state)
               r_bit_cnt <= w_start ? 7'd1 : 7'd0;
            else
               r_bit_cnt <= r_bit_cnt + 7'd1;
            if (r_state == REG)
               r_shift <= {r_shift[WORD_BITS-3:0], w_bit_value};
            if (r_state == GROUP)
               r_grp <= {r_grp[GROUP_BITS-2:0], w_bit_value};
         end

         if (w_cfg_load) begin
            config_word   <= {r_shift, w_bit_value};
            config_strobe <= 1'b1;
            r_half        <= 1'b0;
            r_chip        <= '0;
            r_base        <= '0;
         end

         if (w_grp_done) begin
            r_pend      <= 1'b1;
            r_pend_half <= r_half;
            r_pend_base <= r_base;
            r_half      <= ~r_half;
            if (r_half) begin
               r_chip <= r_chip + 1'b1;
               r_base <= r_base + OFF_W'(WORDS_PER_CHIP);
            end
         end

         if (w_frame_end)
            r_pend <= 1'b0;

         if (w_err_fsm) begin
            r_pend       <= 1'b0;
            busy         <= 1'b0;
            error_strobe <= 1'b1;
         end

         if (w_frame_ok) begin
            frame_strobe <= 1'b1;
            chip_count   <= r_chip;
            busy         <= 1'b0;
         end

         // Commit engine: one buffered word per clk; an in-flight commit
         // always runs to completion, even across an error.
         if (r_cm_act) begin
            if (w_cm_in_range) begin
               write_strobe  <= 1'b1;
               write_address <= ADDRESS_BUS_WIDTH'(START_ADDRESS) + ADDRESS_BUS_WIDTH'(w_cm_off);
               write_data    <= w_cm_word;
            end else if (!r_ovf_seen) begin
               r_ovf_seen   <= 1'b1;
               error_strobe <= 1'b1;
            end
            if (r_cm_k == 3'(WORDS_PER_GROUP - 1))
               r_cm_act <= 1'b0;
            else
               r_cm_k <= r_cm_k + 3'd1;
         end

         if (w_launch) begin
            r_pend    <= 1'b0;
            r_cm_act  <= 1'b1;
            r_cm_k    <= '0;
            r_cm_half <= r_pend_half;
            r_cm_base <= r_pend_base;
         end

         if (w_start) begin
            busy       <= 1'b1;
            r_ovf_seen <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_icnd2110_in.sv
// ---------------------------------------------------------------------------
// tb_icnd2110_in
// Drives ICND2110 frames built from a memory image onto the serial line and
// compares two receivers (default WORD_COUNT and WORD_COUNT=12) against the
// expected memory image, strobe counts and held outputs.
// ---------------------------------------------------------------------------
module tb_icnd2110_in;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst, sclk_in, sdi_in;

   logic [11:0] a_wa, b_wa;
   logic [15:0] a_wd, b_wd, a_cw, b_cw;
   logic [7:0]  a_cc, b_cc;
   logic        a_ws, a_cs, a_fs, a_es, a_busy;
   logic        b_ws, b_cs, b_fs, b_es, b_busy;

   icnd2110_in u_dut_a (
      .clk(clk), .rst(rst), .sclk_in(sclk_in), .sdi_in(sdi_in),
      .write_address(a_wa), .write_data(a_wd), .write_strobe(a_ws),
      .config_word(a_cw), .config_strobe(a_cs), .frame_strobe(a_fs),
      .chip_count(a_cc), .error_strobe(a_es), .busy(a_busy)
   );

   icnd2110_in #(.WORD_COUNT(12)) u_dut_b (
      .clk(clk), .rst(rst), .sclk_in(sclk_in), .sdi_in(sdi_in),
      .write_address(b_wa), .write_data(b_wd), .write_strobe(b_ws),
      .config_word(b_cw), .config_strobe(b_cs), .frame_strobe(b_fs),
      .chip_count(b_cc), .error_strobe(b_es), .busy(b_busy)
   );

   // Event counters and write logs, one slot per DUT
   int          n_w[2]    = '{0, 0};
   int          n_cfg[2]  = '{0, 0};
   int          n_fr[2]   = '{0, 0};
   int          n_err[2]  = '{0, 0};
   int          n_busy[2] = '{0, 0};
   logic [11:0] log_a[2][0:1023];
   logic [15:0] log_d[2][0:1023];

   always @(negedge clk) begin
      if (a_ws && n_w[0] < 1024) begin
         log_a[0][n_w[0]] <= a_wa;
         log_d[0][n_w[0]] <= a_wd;
         n_w[0] <= n_w[0] + 1;
      end
      if (b_ws && n_w[1] < 1024) begin
         log_a[1][n_w[1]] <= b_wa;
         log_d[1][n_w[1]] <= b_wd;
         n_w[1] <= n_w[1] + 1;
      end
      if (a_cs)   n_cfg[0]  <= n_cfg[0] + 1;
      if (b_cs)   n_cfg[1]  <= n_cfg[1] + 1;
      if (a_fs)   n_fr[0]   <= n_fr[0] + 1;
      if (b_fs)   n_fr[1]   <= n_fr[1] + 1;
      if (a_es)   n_err[0]  <= n_err[0] + 1;
      if (b_es)   n_err[1]  <= n_err[1] + 1;
      if (a_busy) n_busy[0] <= n_busy[0] + 1;
      if (b_busy) n_busy[1] <= n_busy[1] + 1;
   end

   int checks = 0;
   int errors = 0;
   int s_w[2], s_cfg[2], s_fr[2], s_err[2], s_busy[2];

   logic [15:0] img[0:23];
   bit          q[$];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic snap();
      for (int d = 0; d < 2; d++) begin
         s_w[d] = n_w[d]; s_cfg[d] = n_cfg[d]; s_fr[d] = n_fr[d];
         s_err[d] = n_err[d]; s_busy[d] = n_busy[d];
      end
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "/a_addr_data"}, {4'h0, a_wa, a_wd}, 32'h0);
      chk({tag, "/a_ctl"}, {3'b0, a_cw, a_cc, a_ws, a_cs, a_fs, a_es, a_busy}, 32'h0);
      chk({tag, "/b_addr_data"}, {4'h0, b_wa, b_wd}, 32'h0);
      chk({tag, "/b_ctl"}, {3'b0, b_cw, b_cc, b_ws, b_cs, b_fs, b_es, b_busy}, 32'h0);
   endtask

   // Writes of a frame must be exactly addresses 0..exp_w-1 holding img[addr]
   task automatic check_dut(input int d, input string tag, input int exp_w, input int exp_err,
                            input int exp_fr, input int exp_cc, input int exp_cfgs,
                            input logic [15:0] exp_cfg);
      bit          seen[0:63];
      logic [11:0] addr;
      logic [15:0] exp_d;
      for (int i = 0; i < 64; i++) seen[i] = 1'b0;
      chk({tag, "/nwrites"}, n_w[d] - s_w[d], exp_w);
      for (int i = s_w[d]; i < n_w[d]; i++) begin
         addr = log_a[d][i];
         chk({tag, "/addr_ok"}, {31'b0, (int'(addr) < exp_w) && !seen[addr[5:0]]}, 1);
         if (addr < 12'd64) seen[addr[5:0]] = 1'b1;
         exp_d = (addr < 12'd24) ? img[addr[4:0]] : 16'hDEAD;
         chk({tag, "/data"}, {16'b0, log_d[d][i]}, {16'b0, exp_d});
      end
      chk({tag, "/errors"}, n_err[d] - s_err[d], exp_err);
      chk({tag, "/frames"}, n_fr[d] - s_fr[d], exp_fr);
      chk({tag, "/chip_count"}, {24'b0, (d == 0) ? a_cc : b_cc}, exp_cc);
      chk({tag, "/cfg_strobes"}, n_cfg[d] - s_cfg[d], exp_cfgs);
      chk({tag, "/config_word"}, {16'b0, (d == 0) ? a_cw : b_cw}, {16'b0, exp_cfg});
      chk({tag, "/busy"}, {31'b0, (d == 0) ? a_busy : b_busy}, 0);
   endtask

   task automatic push_n(input bit v, input int n);
      for (int i = 0; i < n; i++) q.push_back(v);
   endtask

   task automatic push_word(input logic [15:0] w);
      for (int i = 15; i >= 0; i--) q.push_back(w[i]);
   endtask

   // Transmitter view: chip n half h sends img[12n+6h+5] first, down to img[12n+6h]
   task automatic build_frame(input int chips, input logic [15:0] cfg);
      q.delete();
      push_n(1'b0, 8);
      push_n(1'b1, 136);
      push_n(1'b0, 16);
      push_word(cfg);
      for (int n = 0; n < chips; n++)
         for (int h = 0; h < 2; h++) begin
            push_n(1'b0, 16);
            for (int k = 0; k < 6; k++) push_word(img[12*n + 6*h + 5 - k]);
         end
      push_n(1'b0, 16);
      push_n(1'b1, 160);
      push_n(1'b0, 8);
   endtask

   // Half-period of 4 clk on each sclk phase; data changes with sclk falling
   task automatic send_bit(input bit b);
      sclk_in = 1'b0;
      sdi_in  = b;
      repeat (4) @(negedge clk);
      sclk_in = 1'b1;
      repeat (4) @(negedge clk);
   endtask

   task automatic send_q(input int rst_at);
      for (int i = 0; i < q.size(); i++) begin
         send_bit(q[i]);
         if (i == rst_at) begin
            rst = 1'b0;
            repeat (3) @(negedge clk);
            chk_idle("mid_reset");
            rst = 1'b1;
         end
      end
   endtask

   task automatic fill_seq();
      for (int i = 0; i < 24; i++) img[i] = 16'h1000 + 16'(i);
   endtask

   task automatic fill_rand();
      for (int i = 0; i < 24; i++) img[i] = 16'($urandom);
   endtask

   logic [15:0] cfg_r;

   initial begin
      rst     = 1'b0;
      sclk_in = 1'b0;
      sdi_in  = 1'b0;
      repeat (4) @(negedge clk);
      chk_idle("reset");
      rst = 1'b1;
      repeat (2) @(negedge clk);

      // 1 chip, sequential image, loopback-style config
      fill_seq();
      snap();
      build_frame(1, 16'h0017);
      send_q(-1);
      check_dut(0, "seq1_a", 12, 0, 1, 1, 1, 16'h0017);
      check_dut(1, "seq1_b", 12, 0, 1, 1, 1, 16'h0017);

      // 2 chips of all ones: the all-ones first half must not end the frame
      for (int i = 0; i < 24; i++) img[i] = 16'hFFFF;
      snap();
      build_frame(2, 16'hA5A5);
      send_q(-1);
      check_dut(0, "ones2_a", 24, 0, 1, 2, 1, 16'hA5A5);
      check_dut(1, "ones2_b", 12, 1, 1, 2, 1, 16'hA5A5);

      // Stray 1 in the blank after chip 0's second half
      fill_seq();
      snap();
      build_frame(2, 16'h0017);
      q[400] = 1'b1;
      send_q(-1);
      check_dut(0, "inject_a", 6, 1, 0, 2, 1, 16'h0017);
      check_dut(1, "inject_b", 6, 1, 0, 2, 1, 16'h0017);

      // Clean random frame after the error
      fill_rand();
      cfg_r = 16'($urandom);
      snap();
      build_frame(1, cfg_r);
      send_q(-1);
      check_dut(0, "rand1_a", 12, 0, 1, 1, 1, cfg_r);
      check_dut(1, "rand1_b", 12, 0, 1, 1, 1, cfg_r);

      // Reset during bit 40 of the first group
      fill_seq();
      snap();
      build_frame(1, 16'h0017);
      send_q(232);
      check_dut(0, "rstmid_a", 0, 0, 0, 0, 1, 16'h0000);
      check_dut(1, "rstmid_b", 0, 0, 0, 0, 1, 16'h0000);

      // 2 random chips: full write on A, overflow after 12 words on B
      fill_rand();
      cfg_r = 16'($urandom);
      snap();
      build_frame(2, cfg_r);
      send_q(-1);
      check_dut(0, "rand2_a", 24, 0, 1, 2, 1, cfg_r);
      check_dut(1, "rand2_b", 12, 1, 1, 2, 1, cfg_r);

      // End-marker-length run in HUNT never starts a frame
      snap();
      q.delete();
      push_n(1'b1, 145);
      push_n(1'b0, 100);
      send_q(-1);
      check_dut(0, "hunt_a", 0, 0, 0, 2, 0, cfg_r);
      check_dut(1, "hunt_b", 0, 0, 0, 2, 0, cfg_r);
      chk("hunt_a/busy_cycles", n_busy[0] - s_busy[0], 0);
      chk("hunt_b/busy_cycles", n_busy[1] - s_busy[1], 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
